tc_accum_dot: RTL

Streaming multi-beat dot-product engine for vector search. It is the next-generation tensor core. Each beat carries LANES element pairs, which pass through a pipelined multiply and adder tree. A beat accumulator then combines beats, so vectors of any length (LANES × N) reduce to one result. It adds per-vector signed/unsigned element mode, valid/ready backpressure on both sides, beat counting, and sticky overflow and mode-mismatch flags. It sits between the vector fetch unit and the top-k ranking logic.

---
 rtl/tc_accum_dot_if.sv | 37 +++
 rtl/tc_accum_dot.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tc_accum_dot_if.sv
// Beat-in / result-out bundle for the streaming dot-product engine.
// The master drives beats and out_ready; the slave is the engine.
interface tc_accum_dot_if #(
  parameter int ID_W   = 20,
  parameter int LANES  = 64,
  parameter int ELEM_W = 8,
  parameter int ACC_W  = 40
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic              in_signed;
  logic [ID_W-1:0]   in_id;
  logic [ELEM_W-1:0] query_vec [LANES-1:0];
  logic [ELEM_W-1:0] db_vec    [LANES-1:0];
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_dot;
  logic [ID_W-1:0]   out_id;
  logic [15:0]       out_beats;
  logic              out_ovf;
  logic              out_err;

  modport master (
    output in_valid, in_last, in_signed, in_id,
    output query_vec, db_vec, out_ready,
    input  in_ready, out_valid, out_dot, out_id,
    input  out_beats, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_last, in_signed, in_id,
    input  query_vec, db_vec, out_ready,
    output in_ready, out_valid, out_dot, out_id,
    output out_beats, out_ovf, out_err
  );
endinterface

// File: rtl/tc_accum_dot.sv
// Multi-beat dot-product engine: input reg, multiply, adder tree,
// then a beat accumulator that closes each vector into one result.
module tc_accum_dot #(
  parameter int ID_W   = 20,
  parameter int LANES  = 64,
  parameter int ELEM_W = 8,
  parameter int ACC_W  = 40
) (
  input logic clk,
  input logic nrst,
  tc_accum_dot_if.slave bus
);
  localparam int LG = $clog2(LANES);
  localparam int P  = 2*ELEM_W + 1;
  localparam int SW = P + LG;

  if (LANES < 2 || (1 << LG) != LANES) begin : g_bad_lanes
    $error("LANES must be a power of two >= 2");
  end
  if (ACC_W < SW) begin : g_bad_accw
    $error("ACC_W too narrow for the adder tree");
  end

  typedef enum logic {S_IDLE, S_ACC} st_t;

  logic adv;
  logic o_valid;
  assign adv          = !o_valid || bus.out_ready;
  assign bus.in_ready = adv;

  function automatic logic signed [P-1:0] ext(
    input logic [ELEM_W-1:0] x,
    input logic              sg
  );
    ext = {{(P-ELEM_W){sg & x[ELEM_W-1]}}, x};
  endfunction

  logic              r_v, r_l, r_sg;
  logic [ID_W-1:0]   r_id;
  logic [ELEM_W-1:0] r_q [LANES];
  logic [ELEM_W-1:0] r_d [LANES];

  // Input register: capture the beat on every advance.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_v  <= 1'b0;
      r_l  <= 1'b0;
      r_sg <= 1'b0;
      r_id <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_q[i] <= '0;
        r_d[i] <= '0;
      end
    end else if (adv) begin
      r_v  <= bus.in_valid;
      r_l  <= bus.in_last;
      r_sg <= bus.in_signed;
      r_id <= bus.in_id;
      for (int i = 0; i < LANES; i++) begin
        r_q[i] <= bus.query_vec[i];
        r_d[i] <= bus.db_vec[i];
      end
    end
  end

  for (genvar s = 0; s <= LG; s++) begin : g_st
    localparam int W = P + s;
    localparam int N = LANES >> s;
    logic signed [W-1:0] d [N];
    logic                v, l, sg;
    logic [ID_W-1:0]     id;

    if (s == 0) begin : g_mul
      // Product stage: extend per mode, then one signed multiply.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          v  <= 1'b0;
          l  <= 1'b0;
          sg <= 1'b0;
          id <= '0;
          for (int i = 0; i < N; i++) d[i] <= '0;
        end else if (adv) begin
          v  <= r_v;
          l  <= r_l;
          sg <= r_sg;
          id <= r_id;
          for (int i = 0; i < N; i++)
            d[i] <= ext(r_q[i], r_sg) * ext(r_d[i], r_sg);
        end
      end
    end else begin : g_add
      // Tree level: pairwise sums, one bit wider than the level below.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          v  <= 1'b0;
          l  <= 1'b0;
          sg <= 1'b0;
          id <= '0;
          for (int i = 0; i < N; i++) d[i] <= '0;
        end else if (adv) begin
          v  <= g_st[s-1].v;
          l  <= g_st[s-1].l;
          sg <= g_st[s-1].sg;
          id <= g_st[s-1].id;
          for (int i = 0; i < N; i++)
            d[i] <= {g_st[s-1].d[2*i][W-2], g_st[s-1].d[2*i]}
                  + {g_st[s-1].d[2*i+1][W-2], g_st[s-1].d[2*i+1]};
        end
      end
    end
  end

  logic signed [SW-1:0]    t_sum;
  logic                    t_v, t_l, t_sg;
  logic [ID_W-1:0]         t_id;
  assign t_sum = g_st[LG].d[0];
  assign t_v   = g_st[LG].v;
  assign t_l   = g_st[LG].l;
  assign t_sg  = g_st[LG].sg;
  assign t_id  = g_st[LG].id;

  st_t                     st;
  logic signed [ACC_W-1:0] acc;
  logic [15:0]             beats;
  logic                    ovf, err, m_sg;
  logic [ID_W-1:0]         m_id;
  logic [ACC_W-1:0]        o_dot;
  logic [ID_W-1:0]         o_id;
  logic [15:0]             o_beats;
  logic                    o_ovf, o_err;

  logic signed [ACC_W-1:0] sum_x, acc_sum, n_acc;
  logic [15:0]             n_beats;
  logic                    n_ovf, n_err, n_sg, open;
  logic [ID_W-1:0]         n_id;

  // Next accumulator view: fresh vector in IDLE, running sum in ACC.
  always_comb begin
    sum_x   = ACC_W'(t_sum);
    acc_sum = acc + sum_x;
    open    = (st == S_ACC);
    n_acc   = sum_x;
    n_beats = 16'd1;
    n_ovf   = 1'b0;
    n_err   = 1'b0;
    n_sg    = t_sg;
    n_id    = t_id;
    if (open) begin
      n_acc   = acc_sum;
      n_beats = (beats == 16'hFFFF) ? beats : beats + 16'd1;
      n_ovf   = ovf | ((acc[ACC_W-1] == sum_x[ACC_W-1])
                    && (acc_sum[ACC_W-1] != acc[ACC_W-1]));
      n_err   = err | (t_sg != m_sg) | (t_id != m_id);
      n_sg    = m_sg;
      n_id    = m_id;
    end
  end

  // Accumulator FSM and result registers; last beat closes the vector.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st      <= S_IDLE;
      acc     <= '0;
      beats   <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      m_sg    <= 1'b0;
      m_id    <= '0;
      o_valid <= 1'b0;
      o_dot   <= '0;
      o_id    <= '0;
      o_beats <= '0;
      o_ovf   <= 1'b0;
      o_err   <= 1'b0;
    end else if (adv) begin
      o_valid <= t_v && t_l;
      if (t_v) begin
        if (t_l) begin
          o_dot   <= n_acc;
          o_id    <= n_id;
          o_beats <= n_beats;
          o_ovf   <= n_ovf;
          o_err   <= n_err;
          st      <= S_IDLE;
        end else begin
          acc   <= n_acc;
          beats <= n_beats;
          ovf   <= n_ovf;
          err   <= n_err;
          m_sg  <= n_sg;
          m_id  <= n_id;
          st    <= S_ACC;
        end
      end
    end
  end

  assign bus.out_valid = o_valid;
  assign bus.out_dot   = o_dot;
  assign bus.out_id    = o_id;
  assign bus.out_beats = o_beats;
  assign bus.out_ovf   = o_ovf;
  assign bus.out_err   = o_err;
endmodule
